// File: rtl/memory_scheduler_pkg.sv
// Shared state/requester encodings and winner selection for memory_scheduler.
package memory_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    typedef enum logic {
        REQ_ICACHE = 1'b0,
        REQ_DCACHE = 1'b1
    } requester_t;

    // dcache wins unless the icache has been starved up to the limit.
    function automatic requester_t pick_winner(input logic ic_valid,
                                               input logic dc_valid,
                                               input logic at_limit);
        requester_t win;
        if (dc_valid && !(ic_valid && at_limit)) begin
            win = REQ_DCACHE;
        end else begin
            win = REQ_ICACHE;
        end
        return win;
    endfunction

endpackage

// File: rtl/memory_scheduler_starve_counter.sv
// Saturating count of dcache grants taken while an icache request waits.
module starve_counter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic grant_dc,
    input  logic grant_ic,
    input  logic ic_pending,
    output logic at_limit
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear on icache grant, saturating increment on a starving dcache grant.
    always_comb begin
        cnt_d = cnt_q;
        if (grant_ic) begin
            cnt_d = '0;
        end else if (grant_dc && ic_pending && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == LIMIT);

endmodule

// File: rtl/memory_scheduler.sv
// Serialises icache/dcache line requests onto one memory port, one in flight.
// Optional statistics counters are built when MEMORY_SCHEDULER_STATS_EN is defined.
module memory_scheduler
    import memory_scheduler_pkg::*;
#(
    parameter int ADDR_SIZE    = 32,
    parameter int LINE_SIZE    = 256,
    parameter int STARVE_LIMIT = 4
`ifdef MEMORY_SCHEDULER_STATS_EN
    ,
    parameter int STAT_WIDTH   = 32
`endif
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 ic_req_valid_i,
    input  logic [ADDR_SIZE-1:0] ic_req_addr_i,
    input  logic                 ic_req_write_i,
    input  logic [LINE_SIZE-1:0] ic_req_wdata_i,
    output logic                 ic_resp_valid_o,
    output logic [LINE_SIZE-1:0] ic_resp_rdata_o,
    input  logic                 dc_req_valid_i,
    input  logic [ADDR_SIZE-1:0] dc_req_addr_i,
    input  logic                 dc_req_write_i,
    input  logic [LINE_SIZE-1:0] dc_req_wdata_i,
    output logic                 dc_resp_valid_o,
    output logic [LINE_SIZE-1:0] dc_resp_rdata_o,
    output logic                 mem_valid_o,
    input  logic                 mem_ready_i,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    output logic                 mem_write_o,
    output logic [LINE_SIZE-1:0] mem_wdata_o,
    input  logic                 mem_done_i,
    input  logic [LINE_SIZE-1:0] mem_rdata_i,
    output logic                 busy_o
`ifdef MEMORY_SCHEDULER_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_ic_grants_o,
    output logic [STAT_WIDTH-1:0] stat_dc_grants_o,
    output logic [STAT_WIDTH-1:0] stat_forced_o,
    output logic [STAT_WIDTH-1:0] stat_wait_cycles_o
`endif
);
    sched_state_t         state_q, state_d;
    requester_t           id_q, id_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic                 write_q, write_d;
    logic [LINE_SIZE-1:0] wdata_q, wdata_d;
    logic [LINE_SIZE-1:0] ic_rdata_q, ic_rdata_d;
    logic [LINE_SIZE-1:0] dc_rdata_q, dc_rdata_d;
    logic                 mem_valid_q, mem_valid_d;
    logic                 ic_resp_q, ic_resp_d;
    logic                 dc_resp_q, dc_resp_d;
    logic                 busy_q, busy_d;
    logic                 grant_ic_s, grant_dc_s, forced_s, at_limit_s;

    starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .grant_dc   (grant_dc_s),
        .grant_ic   (grant_ic_s),
        .ic_pending (ic_req_valid_i),
        .at_limit   (at_limit_s)
    );

    // FSM next state, request latch and response demux.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        ic_rdata_d = ic_rdata_q;
        dc_rdata_d = dc_rdata_q;
        grant_ic_s = 1'b0;
        grant_dc_s = 1'b0;
        forced_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ic_req_valid_i || dc_req_valid_i) begin
                    id_d = pick_winner(ic_req_valid_i, dc_req_valid_i, at_limit_s);
                    if (id_d == REQ_DCACHE) begin
                        grant_dc_s = 1'b1;
                        addr_d     = dc_req_addr_i;
                        write_d    = dc_req_write_i;
                        wdata_d    = dc_req_wdata_i;
                    end else begin
                        grant_ic_s = 1'b1;
                        // An icache win over a valid dcache request is only possible at the limit.
                        forced_s   = dc_req_valid_i;
                        addr_d     = ic_req_addr_i;
                        write_d    = ic_req_write_i;
                        wdata_d    = ic_req_wdata_i;
                    end
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (mem_ready_i) begin
                    state_d = WAIT;
                end else begin
                    state_d = ISSUE;
                end
            end
            WAIT: begin
                if (mem_done_i) begin
                    if (id_q == REQ_DCACHE) begin
                        dc_rdata_d = mem_rdata_i;
                    end else begin
                        ic_rdata_d = mem_rdata_i;
                    end
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        mem_valid_d = (state_d == ISSUE);
        busy_d      = (state_d != IDLE);
        ic_resp_d   = (state_d == RESP) && (id_d == REQ_ICACHE);
        dc_resp_d   = (state_d == RESP) && (id_d == REQ_DCACHE);
    end

    // Scheduler state and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            id_q        <= REQ_ICACHE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            ic_rdata_q  <= '0;
            dc_rdata_q  <= '0;
            mem_valid_q <= 1'b0;
            ic_resp_q   <= 1'b0;
            dc_resp_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            ic_rdata_q  <= ic_rdata_d;
            dc_rdata_q  <= dc_rdata_d;
            mem_valid_q <= mem_valid_d;
            ic_resp_q   <= ic_resp_d;
            dc_resp_q   <= dc_resp_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_valid_o     = mem_valid_q;
    assign mem_addr_o      = addr_q;
    assign mem_write_o     = write_q;
    assign mem_wdata_o     = wdata_q;
    assign ic_resp_valid_o = ic_resp_q;
    assign dc_resp_valid_o = dc_resp_q;
    assign ic_resp_rdata_o = ic_rdata_q;
    assign dc_resp_rdata_o = dc_rdata_q;
    assign busy_o          = busy_q;

`ifdef MEMORY_SCHEDULER_STATS_EN
    logic [STAT_WIDTH-1:0] ic_grants_q, ic_grants_d;
    logic [STAT_WIDTH-1:0] dc_grants_q, dc_grants_d;
    logic [STAT_WIDTH-1:0] forced_q, forced_d;
    logic [STAT_WIDTH-1:0] wait_cycles_q, wait_cycles_d;

    // Wrapping statistics counters.
    always_comb begin
        ic_grants_d   = ic_grants_q + (grant_ic_s ? STAT_WIDTH'(1) : STAT_WIDTH'(0));
        dc_grants_d   = dc_grants_q + (grant_dc_s ? STAT_WIDTH'(1) : STAT_WIDTH'(0));
        forced_d      = forced_q + ((grant_ic_s && forced_s) ? STAT_WIDTH'(1) : STAT_WIDTH'(0));
        wait_cycles_d = wait_cycles_q +
                        (((state_q == ISSUE) || (state_q == WAIT)) ? STAT_WIDTH'(1) : STAT_WIDTH'(0));
    end

    // Statistics registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ic_grants_q   <= '0;
            dc_grants_q   <= '0;
            forced_q      <= '0;
            wait_cycles_q <= '0;
        end else begin
            ic_grants_q   <= ic_grants_d;
            dc_grants_q   <= dc_grants_d;
            forced_q      <= forced_d;
            wait_cycles_q <= wait_cycles_d;
        end
    end

    assign stat_ic_grants_o   = ic_grants_q;
    assign stat_dc_grants_o   = dc_grants_q;
    assign stat_forced_o      = forced_q;
    assign stat_wait_cycles_o = wait_cycles_q;
`endif

endmodule

// File: tb/tb_memory_scheduler.sv
// Self-checking bench for memory_scheduler: vector table, scoreboarded responses, corner sequences.
module tb_memory_scheduler;
    import memory_scheduler_pkg::*;

    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic         ic_v = 1'b0, ic_w = 1'b0, dc_v = 1'b0, dc_w = 1'b0;
    logic [31:0]  ic_a = '0, dc_a = '0;
    logic [255:0] ic_wd = '0, dc_wd = '0;
    logic         mem_ready = 1'b0, mem_done = 1'b0;
    logic [255:0] mem_rdata = '0;
    logic         ic_rv, dc_rv, mem_valid_o, mem_write_o, busy_o;
    logic [255:0] ic_rd, dc_rd, mem_wdata_o;
    logic [31:0]  mem_addr_o;
`ifdef MEMORY_SCHEDULER_STATS_EN
    logic [31:0]  st_ic, st_dc, st_forced, st_wait;
`endif

    memory_scheduler u_dut (
        .clk_i(clk), .reset_i(reset_i),
        .ic_req_valid_i(ic_v), .ic_req_addr_i(ic_a), .ic_req_write_i(ic_w), .ic_req_wdata_i(ic_wd),
        .ic_resp_valid_o(ic_rv), .ic_resp_rdata_o(ic_rd),
        .dc_req_valid_i(dc_v), .dc_req_addr_i(dc_a), .dc_req_write_i(dc_w), .dc_req_wdata_i(dc_wd),
        .dc_resp_valid_o(dc_rv), .dc_resp_rdata_o(dc_rd),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr_o),
        .mem_write_o(mem_write_o), .mem_wdata_o(mem_wdata_o),
        .mem_done_i(mem_done), .mem_rdata_i(mem_rdata), .busy_o(busy_o)
`ifdef MEMORY_SCHEDULER_STATS_EN
        , .stat_ic_grants_o(st_ic), .stat_dc_grants_o(st_dc),
        .stat_forced_o(st_forced), .stat_wait_cycles_o(st_wait)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         is_dc;
        logic [255:0] rdata;
        logic         chk_data;
    } exp_t;

    typedef struct {
        logic         is_dc;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] rdata;
        int           rdy_wait;
        int           done_wait;
        logic         scramble;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   dc_pulses = 0;
    int   last_dc = -1;
    int   min_gap = 1000;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: every pulse must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (ic_rv || dc_rv) begin
            exp_t e;
            if (ic_rv && dc_rv) begin
                check("resp_both_pulsed", 1'b1, 1'b0);
            end else if (sb_q.size() == 0) begin
                check("resp_unexpected", 1'b1, 1'b0);
            end else begin
                e = sb_q.pop_front();
                check("resp_requester", dc_rv, e.is_dc);
                if (e.chk_data) begin
                    check("resp_rdata", dc_rv ? dc_rd : ic_rd, e.rdata);
                end
            end
            if (dc_rv) begin
                if (last_dc >= 0 && (cyc - last_dc) < min_gap) min_gap = cyc - last_dc;
                last_dc = cyc;
                dc_pulses++;
            end
        end
    end

    task automatic do_reset();
        reset_i = 1'b1;
        ic_v = 1'b0; dc_v = 1'b0; mem_ready = 1'b0; mem_done = 1'b0;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    // Plays the memory side of one transaction; returns at the response cycle.
    task automatic serve(input int rdy_wait, input int done_wait, input logic [255:0] rd,
                         input logic scramble, output int lat, output logic [31:0] a,
                         output logic w, output logic [255:0] wd);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!mem_valid_o && lat < 8);
        a = mem_addr_o; w = mem_write_o; wd = mem_wdata_o;
        if (!mem_valid_o) begin
            check("issue_timeout", 1'b0, 1'b1);
            return;
        end
        if (scramble) begin
            ic_a = 32'hDEAD_BEE0; dc_a = 32'hDEAD_BEE0; ic_wd = ~ic_wd; dc_wd = ~dc_wd;
        end
        for (int i = 0; i < rdy_wait; i++) begin
            mem_done  = (i == 0);
            mem_rdata = ~rd;
            tick();
            check("issue_hold_valid", mem_valid_o, 1'b1);
            check("issue_hold_addr", mem_addr_o, a);
            check("issue_hold_wdata", mem_wdata_o, wd);
        end
        mem_done = 1'b0; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("wait_valid_low", mem_valid_o, 1'b0);
        check("wait_busy", busy_o, 1'b1);
        for (int i = 0; i < done_wait; i++) tick();
        check("done_addr", mem_addr_o, a);
        check("done_wdata", mem_wdata_o, wd);
        mem_done = 1'b1; mem_rdata = rd;
        tick();
        mem_done = 1'b0; mem_rdata = '0;
    endtask

    vec_t         vecs[6];
    int           lat;
    logic [31:0]  a;
    logic         w;
    logic [255:0] wd, rd, rd8, rd9;
    logic         exp_dc;
    int           base;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, {32{8'h11}}, {32{8'hA5}}, 0, 4, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, {32{8'h5A}}, {32{8'h77}}, 2, 3, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0040, {32{8'h22}}, {8{32'h1234_5678}}, 10, 0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0300, {8{32'hCAFE_F00D}}, {32{8'h33}}, 1, 1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFC0, {32{8'h44}}, {32{8'hFF}}, 0, 0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0000, {32{8'h55}}, {8{32'h0BAD_BEEF}}, 0, 2, 1'b0};

        do_reset();
        check("rst_mem_valid", mem_valid_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_ic_resp", ic_rv, 1'b0);
        check("rst_dc_resp", dc_rv, 1'b0);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_mem_write", mem_write_o, 1'b0);
        check("rst_mem_wdata", mem_wdata_o, 256'h0);
        check("rst_ic_rdata", ic_rd, 256'h0);
        check("rst_dc_rdata", dc_rd, 256'h0);

        // Single-requester vectors.
        for (int i = 0; i < 6; i++) begin
            ic_v = !vecs[i].is_dc; dc_v = vecs[i].is_dc;
            ic_a = vecs[i].addr; dc_a = vecs[i].addr;
            ic_w = vecs[i].wr; dc_w = vecs[i].wr;
            ic_wd = vecs[i].wdata; dc_wd = vecs[i].wdata;
            sb_q.push_back('{vecs[i].is_dc, vecs[i].rdata, !vecs[i].wr});
            serve(vecs[i].rdy_wait, vecs[i].done_wait, vecs[i].rdata, vecs[i].scramble, lat, a, w, wd);
            check("vec_latency", 32'(lat), 32'd1);
            check("vec_addr", a, vecs[i].addr);
            check("vec_write", w, vecs[i].wr);
            if (vecs[i].wr) check("vec_wdata", wd, vecs[i].wdata);
            check("vec_ic_pulse", ic_rv, !vecs[i].is_dc);
            check("vec_dc_pulse", dc_rv, vecs[i].is_dc);
            ic_v = 1'b0; dc_v = 1'b0;
            tick();
            check("vec_pulse_one_cycle", {ic_rv, dc_rv}, 2'b00);
            check("vec_idle_busy", busy_o, 1'b0);
        end

        // Both requesters held valid: starvation limit forces every fifth grant to icache.
        do_reset();
        ic_v = 1'b1; ic_a = 32'h0000_1000; ic_w = 1'b0;
        dc_v = 1'b1; dc_a = 32'h0000_2000; dc_w = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_dc = !(i == 4 || i == 9);
            rd = {8{32'hC0DE_0000 + 32'(i)}};
            if (i == 8) rd8 = rd;
            if (i == 9) rd9 = rd;
            sb_q.push_back('{exp_dc, rd, 1'b1});
            serve(0, 0, rd, 1'b0, lat, a, w, wd);
            check("order_addr", a, exp_dc ? 32'h0000_2000 : 32'h0000_1000);
            check("order_latency", 32'(lat), (i == 0) ? 32'd1 : 32'd2);
        end
        ic_v = 1'b0; dc_v = 1'b0;
        tick();
        check("ic_rdata_hold", ic_rd, rd9);
        check("dc_rdata_hold", dc_rd, rd8);
`ifdef MEMORY_SCHEDULER_STATS_EN
        check("stat_forced", st_forced, 32'd2);
        check("stat_ic_grants", st_ic, 32'd2);
        check("stat_dc_grants", st_dc, 32'd8);
        check("stat_wait_cycles", st_wait, 32'd20);
`endif

        // Twenty back-to-back dcache reads at minimum turnaround.
        dc_v = 1'b1; dc_a = 32'h0000_3000; dc_w = 1'b0;
        base = dc_pulses; min_gap = 1000; last_dc = -1;
        for (int i = 0; i < 20; i++) begin
            rd = {8{32'h0D0D_0000 + 32'(i)}};
            sb_q.push_back('{1'b1, rd, 1'b1});
            serve(0, 0, rd, 1'b0, lat, a, w, wd);
        end
        dc_v = 1'b0;
        tick();
        check("b2b_pulses", 32'(dc_pulses - base), 32'd20);
        check("b2b_min_gap", 32'(min_gap), 32'd4);
        check("b2b_starve", 32'(u_dut.u_starve.cnt_q), 32'd0);

        // Reset during WAIT: no response, later done ignored.
        do_reset();
        ic_v = 1'b1; ic_a = 32'h0000_0500; dc_v = 1'b1; dc_a = 32'h0000_0600;
        rd = {32{8'h9C}};
        sb_q.push_back('{1'b1, rd, 1'b1});
        serve(0, 0, rd, 1'b0, lat, a, w, wd);
        check("abort_first_addr", a, 32'h0000_0600);
        tick();
        tick();
        check("abort_issue", mem_valid_o, 1'b1);
        check("abort_issue_addr", mem_addr_o, 32'h0000_0600);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("abort_starve_pre", 32'(u_dut.u_starve.cnt_q), 32'd2);
        reset_i = 1'b1; ic_v = 1'b0; dc_v = 1'b0;
        tick();
        reset_i = 1'b0;
        check("abort_busy", busy_o, 1'b0);
        check("abort_mem_valid", mem_valid_o, 1'b0);
        check("abort_state", 32'(u_dut.state_q), 32'(IDLE));
        check("abort_starve", 32'(u_dut.u_starve.cnt_q), 32'd0);
        mem_done = 1'b1; mem_rdata = {32{8'hEE}};
        tick();
        mem_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_pulse", {ic_rv, dc_rv}, 2'b00);
            check("abort_busy_stays", busy_o, 1'b0);
        end

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_scheduler.md
# memory_scheduler

Line-granular request scheduler between the instruction cache, the data cache and the single backing memory. It accepts one outstanding line read or write from each cache and serialises them onto the memory port with exactly one transaction in flight. Data-side requests have priority, and a starvation limit guarantees instruction fetch forward progress. It sits where the cache-to-memory arbitration point is in the top level.

## Interface
Parameters:
- ADDR_SIZE, 32, byte address width
- LINE_SIZE, 256, line width in bits
- STARVE_LIMIT, 4, consecutive dcache grants allowed while an icache request waits (≥1)
- STAT_WIDTH, 32, statistics counter width (only with MEMORY_SCHEDULER_STATS_EN)

Ports:
- clk_i  in  1  clock, all state on rising edge
- reset_i  in  1  synchronous, active-high reset
- ic_req_valid_i  in  1  icache request pending; held until ic_resp_valid_o
- ic_req_addr_i  in  ADDR_SIZE  line address
- ic_req_write_i  in  1  1 = line write, 0 = line read
- ic_req_wdata_i  in  LINE_SIZE  write data
- ic_resp_valid_o  out  1  one-cycle completion pulse
- ic_resp_rdata_o  out  LINE_SIZE  read data, valid with ic_resp_valid_o
- dc_req_valid_i, dc_req_addr_i, dc_req_write_i, dc_req_wdata_i, dc_resp_valid_o, dc_resp_rdata_o  same as ic_*, data side
- mem_valid_o  out  1  memory request valid
- mem_ready_i  in  1  memory accepts request this cycle
- mem_addr_o  out  ADDR_SIZE  latched request address
- mem_write_o  out  1  latched write flag
- mem_wdata_o  out  LINE_SIZE  latched write data
- mem_done_i  in  1  memory completion pulse
- mem_rdata_i  in  LINE_SIZE  read data, valid with mem_done_i
- busy_o  out  1  state ≠ IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: pick a winner if any request is valid, latch its id, addr, write and wdata, then go to ISSUE.
- Winner selection:
  - dcache wins unless starve_cnt == STARVE_LIMIT and an icache request is valid; then icache is forced.
  - Only one valid request: that requester wins.
- ISSUE: mem_valid_o = 1 with the latched fields. On mem_ready_i go to WAIT.
- WAIT: on mem_done_i, register mem_rdata_i into the response register (writes register it too, contents don't-care), then go to RESP.
- RESP: assert the winner's resp_valid for exactly one cycle, then go to IDLE.
- starve_cnt, width $clog2(STARVE_LIMIT+1), updated when leaving IDLE:
  - dcache granted while ic_req_valid_i = 1: increment, saturating at STARVE_LIMIT.
  - icache granted: clear.
  - Otherwise: hold.
- Requester contract: keep the request stable until its resp pulse. The cycle after the resp pulse, either deassert valid or present a new request.
- Latched fields are immune to input changes after IDLE.
- mem_done_i outside WAIT and mem_ready_i outside ISSUE are ignored.
- resp_rdata outputs hold their last value between pulses.

## Timing
- Reset values:
  - mem_valid_o, ic_resp_valid_o, dc_resp_valid_o, busy_o = 0.
  - mem_addr_o, mem_write_o, mem_wdata_o, resp_rdata = 0.
  - starve_cnt = 0, state = IDLE.
- Reset mid-transaction: abort to IDLE with no response pulse. Any later mem_done_i for the aborted request is ignored.
- Request visible at cycle 0 in IDLE: mem_valid_o at cycle 1. With mem_ready_i at cycle 1, WAIT from cycle 2.
- mem_done_i at cycle k: resp pulse at k+1, IDLE at k+2. The next winner is evaluated at k+2 and issued at k+3.
- Minimum turnaround, with ready and done both at the first opportunity: 4 cycles per transaction.
- Simultaneous ic/dc requests arriving in the same IDLE cycle: selection per the starvation rule.

## Configuration
- MEMORY_SCHEDULER_STATS_EN defined adds these outputs, each STAT_WIDTH bits, wrapping, reset to 0:
  - stat_ic_grants_o: increments on each icache grant.
  - stat_dc_grants_o: increments on each dcache grant.
  - stat_forced_o: increments on each starvation-forced icache grant.
  - stat_wait_cycles_o: increments on each ISSUE/WAIT cycle.
- MEMORY_SCHEDULER_STATS_EN undefined: these ports and counters are absent. Functional behaviour is identical.

## Structure
- Shared definitions package:
  - enum sched_state_t {IDLE, ISSUE, WAIT, RESP}
  - enum requester_t {REQ_ICACHE, REQ_DCACHE}
- One sub-module, starve_counter, holding the saturating counter. Interface: grant_dc, grant_ic, ic_pending, at_limit.
- Request latch, FSM and response demux live in memory_scheduler.

## Test plan
- Single icache read addr 0x100, mem_ready at cycle 1, done at cycle 6 with rdata 0xA5 pattern → ic_resp_valid_o at cycle 7 carrying 0xA5 pattern; dc_resp_valid_o stays 0.
- ic and dc both held valid continuously, STARVE_LIMIT=4 → grant order D,D,D,D,I,D,D,D,D,I; stat_forced_o = 2.
- dcache write addr 0x2000, wdata 0x5A pattern; inputs changed after cycle 0 → mem_addr_o/mem_wdata_o stay 0x2000/0x5A until done.
- mem_ready_i held low 10 cycles → mem_valid_o high and fields stable for all 10 cycles; mem_done_i pulsed during ISSUE is ignored.
- reset_i asserted during WAIT, then mem_done_i → no resp pulse, state IDLE, busy_o = 0, starve_cnt = 0.
- Only dcache requests, 20 back-to-back → starve_cnt stays 0, 20 dc pulses spaced ≥4 cycles apart.
